cu_struct_cmd_arbiter: RTL and testbench
========================================

CU_STRUCT_CMD_ARBITER -- requirements
Module: cu_struct_cmd_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requester channels, range 2..16.
REQ-002 SHALL have parameter ADDR_W, default 64: command address width.
REQ-003 SHALL have parameter TAG_W, default 8: issued-command tag width.
REQ-004 SHALL have parameter CNT_W, default 8: outstanding-counter width.
REQ-005 SHALL have parameters MAX_READ, MAX_WRITE and MAX_PREFETCH, defaults 32, 32 and 16: per-type outstanding limits, each less than or equal to 2^CNT_W-1.
REQ-006 SHALL use the struct-type encoding STRUCT_INVALID=0, READ_DATA=1, WRITE_DATA=2, PREFETCH_DATA=3, carried on 2 bits.
REQ-007 SHALL have the following ports, one per line as name, direction, width, meaning:
- clock, in, 1: single clock; all logic on its rising edge.
- reset, in, 1: synchronous, active-high reset.
- enable, in, 1: grants are permitted only while high.
- flush, in, 1: level request to stop granting and drain.
- req_valid, in, NUM_REQ: per-channel request valid.
- req_struct, in, 2*NUM_REQ: per-channel struct type.
- req_addr, in, ADDR_W*NUM_REQ: per-channel address.
- req_ready, out, NUM_REQ: per-channel accept, combinational.
- cmd_valid, out, 1: registered command valid.
- cmd_struct, out, 2: struct type of the command.
- cmd_addr, out, ADDR_W: address of the command.
- cmd_src, out, $clog2(NUM_REQ): index of the granted channel.
- cmd_tag, out, TAG_W: sequence tag of the command.
- cmd_ready, in, 1: downstream accept.
- rsp_valid, in, 1: completion pulse.
- rsp_struct, in, 2: struct type of the completion.
- out_read, out, CNT_W: outstanding READ_DATA count.
- out_write, out, CNT_W: outstanding WRITE_DATA count.
- out_prefetch, out, CNT_W: outstanding PREFETCH_DATA count.
- done, out, 1: drain complete.
- err, out, 1: sticky error flag.

Function
REQ-008 SHALL hold a one-entry output slot, with the slot free when cmd_valid=0 or when cmd_valid and cmd_ready are both high.
REQ-009 SHALL deem channel i eligible when all of the following hold: req_valid[i]=1; its struct type is not 0; the count for that type is below the corresponding MAX_*; state is RUN; enable=1.
REQ-010 SHALL, when the slot is free, grant the first eligible channel at or after rr_ptr and assert req_ready for that channel only.
REQ-011 SHALL load the slot on a grant at the next clock edge, giving a latency of 1 cycle from grant to cmd_valid.
REQ-012 SHALL set rr_ptr to (granted index+1) mod NUM_REQ after each grant, and leave rr_ptr unchanged when no grant occurs.
REQ-013 SHALL keep cmd_struct, cmd_addr, cmd_src and cmd_tag stable while cmd_valid=1 and cmd_ready=0.
REQ-014 SHALL increment cmd_tag by 1 for each grant, wrapping modulo 2^TAG_W.
REQ-015 SHALL increment the counter for the granted type on each grant.
REQ-016 SHALL decrement the matching counter on rsp_valid.
REQ-017 SHALL leave the counter unchanged when a grant and a response of the same type occur in the same cycle.
REQ-018 SHALL, on rsp_valid with its counter at 0, hold the counter at 0 and set err.
REQ-019 SHALL, on rsp_valid with rsp_struct=0, change no counter and set err.
REQ-020 SHALL, for any channel with req_valid=1 and struct 0, assert req_ready that cycle regardless of grant, drop the request and set err.
REQ-021 SHALL implement the states RUN, DRAIN and DONE with these transitions:
- RUN to DRAIN when flush=1.
- DRAIN to DONE when the slot is empty and all three counters are 0.
- DONE to RUN when flush=0.
- The slot keeps draining and responses keep decrementing counters in DRAIN.
REQ-022 SHALL assert done if and only if state is DONE.
REQ-023 SHALL let enable=0 only block new grants, without affecting the slot, the counters or the state.

Reset
REQ-024 SHALL, while reset=1 at a clock edge, clear all state: cmd_valid=0, cmd_tag=0, rr_ptr=0, all counters=0, err=0, state=RUN, done=0.
REQ-025 SHALL hold req_ready at 0 during reset.
REQ-026 SHALL discard any in-flight slot content on reset with no further cmd_valid, and SHALL ignore responses arriving during reset.

Verification
REQ-027 SHALL be verified with the following directed scenarios, each as stimulus and required response:
- Round robin: NUM_REQ=4, all channels READ_DATA, cmd_ready=1 → grants 0,1,2,3,0 in consecutive cycles, cmd_tag 0..4, out_read rising to 5.
- Limit: MAX_PREFETCH=16, 17 PREFETCH_DATA requests, no responses → 16 issued, 17th held with req_ready=0, out_prefetch=16; one response → 17th issued next cycle.
- Backpressure: cmd_ready=0 for 5 cycles → cmd fields constant, no further grant, out_write unchanged.
- Simultaneous events: grant and response both WRITE_DATA with out_write=3 → out_write stays 3.
- Errors: response with out_read=0 → out_read stays 0, err=1 sticky; struct-0 request → req_ready=1 that cycle, no cmd issued.
- Drain and reset: flush=1 with 2 reads outstanding → no grants, done=1 one cycle after the last response; flush=0 → RUN; reset mid-burst → all outputs at reset values next cycle.

Source files
------------

// File: rtl/cu_struct_cmd_arbiter.sv
// Round-robin arbiter that issues typed commands through a one-entry output slot,
// tracks outstanding commands per type and supports a flush/drain handshake.
//
// state    | meaning
// ST_RUN   | normal arbitration, grants allowed while enable is high
// ST_DRAIN | grants stopped; slot and responses keep draining
// ST_DONE  | slot empty and all counters zero; done high until flush drops
module cu_struct_cmd_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_W       = 64,
  parameter int TAG_W        = 8,
  parameter int CNT_W        = 8,
  parameter int MAX_READ     = 32,
  parameter int MAX_WRITE    = 32,
  parameter int MAX_PREFETCH = 16,
  localparam int SRC_W       = $clog2(NUM_REQ)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [2*NUM_REQ-1:0]      req_struct,
  input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      cmd_valid,
  output logic [1:0]                cmd_struct,
  output logic [ADDR_W-1:0]         cmd_addr,
  output logic [SRC_W-1:0]          cmd_src,
  output logic [TAG_W-1:0]          cmd_tag,
  input  logic                      cmd_ready,
  input  logic                      rsp_valid,
  input  logic [1:0]                rsp_struct,
  output logic [CNT_W-1:0]          out_read,
  output logic [CNT_W-1:0]          out_write,
  output logic [CNT_W-1:0]          out_prefetch,
  output logic                      done,
  output logic                      err
);

  typedef enum logic [1:0] {
    STRUCT_INVALID = 2'd0,
    READ_DATA      = 2'd1,
    WRITE_DATA     = 2'd2,
    PREFETCH_DATA  = 2'd3
  } struct_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e             state;
  logic [SRC_W-1:0]   rr_ptr;
  logic [TAG_W-1:0]   tag_ctr;

  logic [1:0]         ch_struct [NUM_REQ];
  logic [ADDR_W-1:0]  ch_addr   [NUM_REQ];
  logic [NUM_REQ-1:0] req_bad;
  logic [NUM_REQ-1:0] eligible;
  logic [3:0]         below_lim;

  logic               slot_free;
  logic               gnt_any;
  logic [SRC_W-1:0]   gnt_idx;
  logic [SRC_W-1:0]   cand;
  logic [1:0]         gnt_struct;
  logic [ADDR_W-1:0]  gnt_addr;

  logic               inc_rd, inc_wr, inc_pf;
  logic               dec_rd, dec_wr, dec_pf;
  logic [CNT_W-1:0]   read_nxt, write_nxt, pf_nxt;
  logic               underflow;
  logic               err_set;
  logic               slot_nxt;
  logic               drained;

  function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] cnt,
                                                  input logic inc,
                                                  input logic dec);
    logic [CNT_W-1:0] r;
    r = cnt;
    if (inc && !dec)
      r = cnt + CNT_W'(1);
    else if (dec && !inc && cnt != '0)
      r = cnt - CNT_W'(1);
    return r;
  endfunction

  // Index 0 stays low so an invalid struct can never pass the limit check.
  always_comb begin
    below_lim                = 4'b0000;
    below_lim[READ_DATA]     = out_read     < CNT_W'(MAX_READ);
    below_lim[WRITE_DATA]    = out_write    < CNT_W'(MAX_WRITE);
    below_lim[PREFETCH_DATA] = out_prefetch < CNT_W'(MAX_PREFETCH);
  end

  always_comb begin
    req_bad  = '0;
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ch_struct[i] = req_struct[2*i +: 2];
      ch_addr[i]   = req_addr[ADDR_W*i +: ADDR_W];
      req_bad[i]   = req_valid[i] && (ch_struct[i] == STRUCT_INVALID);
      eligible[i]  = req_valid[i] && (ch_struct[i] != STRUCT_INVALID) &&
                     below_lim[ch_struct[i]] && (state == ST_RUN) && enable;
    end
  end

  assign slot_free = !cmd_valid || cmd_ready;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = SRC_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!gnt_any && eligible[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (reset || !slot_free)
      gnt_any = 1'b0;
  end

  assign gnt_struct = ch_struct[gnt_idx];
  assign gnt_addr   = ch_addr[gnt_idx];

  // Struct-0 requests are acknowledged and dropped even when no grant happens.
  always_comb begin
    req_ready = '0;
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++)
        req_ready[i] = req_bad[i] || (gnt_any && (gnt_idx == SRC_W'(i)));
    end
  end

  always_comb begin
    inc_rd    = gnt_any && (gnt_struct == READ_DATA);
    inc_wr    = gnt_any && (gnt_struct == WRITE_DATA);
    inc_pf    = gnt_any && (gnt_struct == PREFETCH_DATA);
    dec_rd    = rsp_valid && (rsp_struct == READ_DATA);
    dec_wr    = rsp_valid && (rsp_struct == WRITE_DATA);
    dec_pf    = rsp_valid && (rsp_struct == PREFETCH_DATA);
    read_nxt  = next_count(out_read,     inc_rd, dec_rd);
    write_nxt = next_count(out_write,    inc_wr, dec_wr);
    pf_nxt    = next_count(out_prefetch, inc_pf, dec_pf);
    underflow = (dec_rd && out_read == '0) || (dec_wr && out_write == '0) ||
                (dec_pf && out_prefetch == '0);
    err_set   = underflow || (rsp_valid && rsp_struct == STRUCT_INVALID) || (|req_bad);
    slot_nxt  = gnt_any || (cmd_valid && !cmd_ready);
    // Look at next-cycle values so done follows the last response by one cycle.
    drained   = !slot_nxt && (read_nxt == '0) && (write_nxt == '0) && (pf_nxt == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_RUN;
      done         <= 1'b0;
      err          <= 1'b0;
      rr_ptr       <= '0;
      tag_ctr      <= '0;
      cmd_valid    <= 1'b0;
      cmd_struct   <= '0;
      cmd_addr     <= '0;
      cmd_src      <= '0;
      cmd_tag      <= '0;
      out_read     <= '0;
      out_write    <= '0;
      out_prefetch <= '0;
    end else begin
      if (gnt_any) begin
        cmd_valid  <= 1'b1;
        cmd_struct <= gnt_struct;
        cmd_addr   <= gnt_addr;
        cmd_src    <= gnt_idx;
        cmd_tag    <= tag_ctr;
        tag_ctr    <= tag_ctr + TAG_W'(1);
        rr_ptr     <= (gnt_idx == SRC_W'(NUM_REQ - 1)) ? '0 : gnt_idx + SRC_W'(1);
      end else if (cmd_ready) begin
        cmd_valid  <= 1'b0;
      end

      out_read     <= read_nxt;
      out_write    <= write_nxt;
      out_prefetch <= pf_nxt;
      if (err_set)
        err <= 1'b1;

      case (state)
        ST_RUN: begin
          if (flush)
            state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (drained) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!flush) begin
            state <= ST_RUN;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= ST_RUN;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cu_struct_cmd_arbiter.sv
// Bench for cu_struct_cmd_arbiter: directed scenarios plus random traffic against a
// per-cycle reference model; issued commands are checked through a scoreboard queue.
module tb_cu_struct_cmd_arbiter;
  localparam int N  = 4;
  localparam int AW = 64;
  localparam int TW = 8;
  localparam int CW = 8;
  localparam int MR = 32;
  localparam int MW = 32;
  localparam int MP = 16;
  localparam int SW = $clog2(N);

  localparam int M_RUN = 0, M_DRAIN = 1, M_DONE = 2;

  logic            clock = 1'b0;
  logic            reset, enable, flush;
  logic [N-1:0]    req_valid;
  logic [2*N-1:0]  req_struct;
  logic [AW*N-1:0] req_addr;
  logic [N-1:0]    req_ready;
  logic            cmd_valid;
  logic [1:0]      cmd_struct;
  logic [AW-1:0]   cmd_addr;
  logic [SW-1:0]   cmd_src;
  logic [TW-1:0]   cmd_tag;
  logic            cmd_ready;
  logic            rsp_valid;
  logic [1:0]      rsp_struct;
  logic [CW-1:0]   out_read, out_write, out_prefetch;
  logic            done, err;

  cu_struct_cmd_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .TAG_W(TW), .CNT_W(CW),
    .MAX_READ(MR), .MAX_WRITE(MW), .MAX_PREFETCH(MP)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .flush(flush),
    .req_valid(req_valid), .req_struct(req_struct), .req_addr(req_addr),
    .req_ready(req_ready), .cmd_valid(cmd_valid), .cmd_struct(cmd_struct),
    .cmd_addr(cmd_addr), .cmd_src(cmd_src), .cmd_tag(cmd_tag),
    .cmd_ready(cmd_ready), .rsp_valid(rsp_valid), .rsp_struct(rsp_struct),
    .out_read(out_read), .out_write(out_write), .out_prefetch(out_prefetch),
    .done(done), .err(err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]    st;
    logic [AW-1:0] addr;
    int            src;
    int            tag;
  } cmd_t;

  cmd_t         exp_q[$];
  int           m_cnt [4];
  int           m_max [4];
  int           m_rr, m_tag, m_state, m_idx;
  bit           m_slot, m_err, m_gnt;
  logic [N-1:0] m_rdy;
  logic [N-1:0] rr_seen;
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int struct_of(input int ch);
    return int'(req_struct[2*ch +: 2]);
  endfunction

  task automatic model_comb();
    m_gnt = 1'b0;
    m_idx = 0;
    m_rdy = '0;
    if (!reset) begin
      for (int i = 0; i < N; i++)
        if (req_valid[i] && struct_of(i) == 0) m_rdy[i] = 1'b1;
      if (m_state == M_RUN && enable && (!m_slot || cmd_ready)) begin
        for (int k = 0; k < N; k++) begin
          int i, t;
          i = (m_rr + k) % N;
          t = struct_of(i);
          if (!m_gnt && req_valid[i] && t != 0 && m_cnt[t] < m_max[t]) begin
            m_gnt = 1'b1;
            m_idx = i;
          end
        end
      end
      if (m_gnt) m_rdy[m_idx] = 1'b1;
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      foreach (m_cnt[t]) m_cnt[t] = 0;
      m_rr = 0; m_tag = 0; m_state = M_RUN; m_slot = 1'b0; m_err = 1'b0;
      exp_q.delete();
    end else begin
      int gst;
      gst = m_gnt ? struct_of(m_idx) : 0;
      for (int t = 1; t < 4; t++) begin
        bit inc, dec;
        inc = m_gnt && gst == t;
        dec = rsp_valid && int'(rsp_struct) == t;
        if (dec && m_cnt[t] == 0) m_err = 1'b1;
        if (inc && !dec) m_cnt[t]++;
        else if (dec && !inc && m_cnt[t] > 0) m_cnt[t]--;
      end
      if (rsp_valid && rsp_struct == 2'd0) m_err = 1'b1;
      for (int i = 0; i < N; i++)
        if (req_valid[i] && struct_of(i) == 0) m_err = 1'b1;
      if (m_slot && cmd_ready) m_slot = 1'b0;
      if (m_gnt) begin
        cmd_t e;
        e.st   = 2'(gst);
        e.addr = req_addr[m_idx*AW +: AW];
        e.src  = m_idx;
        e.tag  = m_tag;
        exp_q.push_back(e);
        m_slot = 1'b1;
        m_tag  = (m_tag + 1) % (1 << TW);
        m_rr   = (m_idx + 1) % N;
      end
      case (m_state)
        M_RUN:   if (flush) m_state = M_DRAIN;
        M_DRAIN: if (!m_slot && m_cnt[1] + m_cnt[2] + m_cnt[3] == 0) m_state = M_DONE;
        default: if (!flush) m_state = M_RUN;
      endcase
    end
  endtask

  // One clock: combinational check mid-cycle, model update at the edge, registered check after.
  task automatic step();
    #1;
    model_comb();
    rr_seen = req_ready;
    chk("req_ready", req_ready, m_rdy);
    @(posedge clock);
    model_edge();
    #1;
    chk("cmd_valid", cmd_valid, m_slot);
    chk("out_read", out_read, m_cnt[1]);
    chk("out_write", out_write, m_cnt[2]);
    chk("out_prefetch", out_prefetch, m_cnt[3]);
    chk("err", err, m_err);
    chk("done", done, m_state == M_DONE);
  endtask

  always @(negedge clock) begin
    if (!reset && cmd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL cmd_unexpected: got command from src %0d tag %0d, expected none", cmd_src, cmd_tag);
      end else begin
        chk("cmd_struct", cmd_struct, exp_q[0].st);
        chk("cmd_addr", cmd_addr, exp_q[0].addr);
        chk("cmd_src", cmd_src, exp_q[0].src);
        chk("cmd_tag", cmd_tag, exp_q[0].tag);
        if (cmd_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic drive_req(input logic [N-1:0] v, input logic [1:0] st);
    req_valid = v;
    for (int i = 0; i < N; i++) begin
      req_struct[2*i +: 2] = st;
      req_addr[i*AW +: AW] = {$urandom(), $urandom()};
    end
  endtask

  task automatic rsp(input logic [1:0] st);
    rsp_valid  = 1'b1;
    rsp_struct = st;
    step();
    rsp_valid  = 1'b0;
  endtask

  initial begin
    m_max[0] = 0; m_max[1] = MR; m_max[2] = MW; m_max[3] = MP;
    foreach (m_cnt[t]) m_cnt[t] = 0;
    m_rr = 0; m_tag = 0; m_state = M_RUN; m_slot = 1'b0; m_err = 1'b0;

    reset = 1'b1; enable = 1'b1; flush = 1'b0; cmd_ready = 1'b1;
    rsp_valid = 1'b1; rsp_struct = 2'd1;
    drive_req('1, 2'd1);
    repeat (2) step();
    chk("reset_cmd_tag", cmd_tag, 0);
    reset = 1'b0; rsp_valid = 1'b0;
    drive_req('0, 2'd1);
    step();

    // round robin over four READ requesters
    drive_req('1, 2'd1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rr_grant", rr_seen, 4'b0001 << (k % 4));
    end
    chk("rr_out_read", out_read, 5);
    drive_req('0, 2'd1);
    step();
    repeat (5) rsp(2'd1);

    // prefetch limit
    drive_req('1, 2'd3);
    repeat (16) step();
    step();
    chk("limit_held", rr_seen, 0);
    chk("limit_count", out_prefetch, 16);
    rsp(2'd3);
    chk("limit_held_rsp", rr_seen, 0);
    step();
    chk("limit_17th", rr_seen, 4'b0010);
    chk("limit_count2", out_prefetch, 16);
    drive_req('0, 2'd3);
    step();
    repeat (16) rsp(2'd3);

    // backpressure
    drive_req('1, 2'd2);
    step();
    cmd_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_no_grant", rr_seen, 0);
      chk("bp_out_write", out_write, 1);
    end
    cmd_ready = 1'b1;
    drive_req('0, 2'd2);
    step();
    rsp(2'd2);

    // grant and response of the same type in one cycle
    drive_req('1, 2'd2);
    repeat (3) step();
    chk("simul_pre", out_write, 3);
    rsp(2'd2);
    chk("simul_out_write", out_write, 3);
    drive_req('0, 2'd2);
    step();
    repeat (3) rsp(2'd2);

    // errors
    chk("err_clear", err, 0);
    rsp(2'd1);
    chk("underflow_cnt", out_read, 0);
    chk("underflow_err", err, 1);
    step();
    chk("err_sticky", err, 1);
    drive_req(4'b0100, 2'd0);
    step();
    chk("bad_req_ready", rr_seen, 4'b0100);
    chk("bad_no_cmd", cmd_valid, 0);
    drive_req('0, 2'd1);

    // drain
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("reset_err", err, 0);
    drive_req(4'b0001, 2'd1);
    repeat (2) step();
    drive_req('0, 2'd1);
    step();
    chk("drain_pre", out_read, 2);
    flush = 1'b1;
    step();
    drive_req('1, 2'd1);
    step();
    chk("drain_no_grant", rr_seen, 0);
    rsp(2'd1);
    chk("drain_no_grant2", rr_seen, 0);
    chk("drain_not_done", done, 0);
    rsp(2'd1);
    chk("drain_done", done, 1);
    flush = 1'b0;
    step();
    chk("drain_back_run", done, 0);
    step();
    chk("drain_regrant", rr_seen, 4'b0010);

    // reset with a command stuck in the slot
    cmd_ready = 1'b0;
    step();
    reset = 1'b1; rsp_valid = 1'b1; rsp_struct = 2'd1;
    step();
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_out_read", out_read, 0);
    chk("rst_done", done, 0);
    chk("rst_tag", cmd_tag, 0);
    reset = 1'b0; rsp_valid = 1'b0; cmd_ready = 1'b1;
    drive_req('0, 2'd1);
    step();
    chk("rst_quiet", cmd_valid, 0);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] v;
      reset     = ($urandom_range(0, 999) == 0);
      enable    = ($urandom_range(0, 9) != 0);
      cmd_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 99) < 3) flush = ~flush;
      v = $urandom();
      req_valid = v[N-1:0];
      for (int i = 0; i < N; i++) begin
        int r;
        r = $urandom_range(0, 19);
        req_struct[2*i +: 2] = (r == 0) ? 2'd0 : 2'(1 + r % 3);
        req_addr[i*AW +: AW] = {$urandom(), $urandom()};
      end
      rsp_valid = 1'b0;
      rsp_struct = 2'd0;
      if ($urandom_range(0, 9) < 4) begin
        int t;
        t = $urandom_range(1, 3);
        if (m_cnt[t] > 0) begin
          rsp_valid  = 1'b1;
          rsp_struct = 2'(t);
        end
      end
      if ($urandom_range(0, 199) == 0) begin
        rsp_valid  = 1'b1;
        rsp_struct = 2'd0;
      end
      step();
    end

    reset = 1'b0; flush = 1'b0; enable = 1'b1; cmd_ready = 1'b1; rsp_valid = 1'b0;
    drive_req('0, 2'd1);
    repeat (3) step();
    chk("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
